ad_acq_ctrl: RTL
================

Name: ad_acq_ctrl

Overview:
Acquisition controller between the serial ADC deserialiser (ad_data/ad_vld) and the downstream sample consumer.
It arms on a register-driven start, waits for a selectable trigger, then captures a programmed number of decimated samples.
Captured samples go into a 2-entry output buffer with a valid/ready handshake.
It reports busy, done, overflow and progress back to the register file.

Parameters:
DW, 16, sample width (ad_data, trig_level, out_data)
CW, 16, sample-count width (num_samp, samp_cnt)

Ports:
clk_sys  in  1  system clock; all logic on rising edge
rst  in  1  reset; asynchronous, active-high
start  in  1  one-cycle pulse; arm acquisition (ignored unless IDLE)
abort  in  1  one-cycle pulse; cancel acquisition from any state
trig_mode  in  2  0 immediate, 1 rising threshold, 2 falling threshold, 3 external
trig_level  in  DW  signed threshold for modes 1/2
trig_ext  in  1  external trigger level (mode 3, rising edge detected internally)
decim  in  8  keep 1 of every decim+1 samples
num_samp  in  CW  kept samples per capture; 0 = continuous until abort
ad_data  in  DW  signed sample from deserialiser
ad_vld  in  1  one-cycle strobe, ad_data valid
out_data  out  DW  buffered sample, head of buffer
out_vld  out  1  buffer non-empty
out_rdy  in  1  consumer accepts; transfer when out_vld && out_rdy
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when capture fully drained
ovf  out  1  sticky; a kept sample was dropped because the buffer was full
state  out  2  0 IDLE, 1 WAIT_TRIG, 2 CAPTURE, 3 FLUSH
samp_cnt  out  CW  kept samples written so far in this capture, including dropped ones

Behaviour:
- Reset (async, rst=1): state=IDLE. out_vld=0, out_data=0, busy=0, done=0, ovf=0, samp_cnt=0. Buffer empty; prev-sample register=0; trig_ext edge register=0; decimation counter=0.
- Configuration inputs (trig_mode, trig_level, decim, num_samp) are latched on the accepted start. Later changes have no effect until the next start.
- IDLE:
  - start -> WAIT_TRIG next cycle.
  - On the same edge: samp_cnt=0, ovf=0, decimation counter=0, prev-sample register loaded with the current ad_data.
- WAIT_TRIG: the prev-sample register updates on every ad_vld.
  - Mode 0: the first ad_vld in WAIT_TRIG is the trigger sample.
  - Mode 1: the trigger sample is an ad_vld where prev < trig_level <= ad_data (signed).
  - Mode 2: the trigger sample is an ad_vld where prev > trig_level >= ad_data (signed).
  - Mode 3: the first ad_vld at or after a 0->1 edge of trig_ext. The edge is remembered until that ad_vld arrives.
  - On the trigger sample, the sample itself is the first kept sample: pushed to the buffer, samp_cnt=1, decimation counter=0. State -> CAPTURE.
  - If num_samp==1, state goes -> FLUSH instead.
- CAPTURE, each ad_vld:
  - If decimation counter==decim: counter=0, sample kept (push, samp_cnt+1).
  - Otherwise the counter increments and the sample is discarded.
  - After the kept push where samp_cnt reaches num_samp (num_samp != 0) -> FLUSH; later ad_vld are ignored.
  - samp_cnt wraps modulo 2^CW in continuous mode.
- FLUSH: wait until the buffer is empty, then pulse done for one cycle and -> IDLE on the same edge.
- Buffer: 2-entry FIFO; out_data is the head and is registered.
  - Push latency: sample in on ad_vld at edge N, out_vld=1 after edge N.
  - Push and pop in the same cycle are both honoured, including when full.
  - Push while full and no pop: the sample is dropped, ovf=1 (sticky until next start), and samp_cnt still increments.
- abort, any state: next state IDLE, buffer flushed (out_vld=0), no done pulse, ovf and samp_cnt hold for readback.
  - abort has priority over start and over a simultaneous trigger or push.
- start while busy: ignored.
- start and abort together in IDLE: abort wins, stays IDLE.

Test Plan:
1. Mode 0, decim=0, num_samp=4, out_rdy=1, ad_vld every 16 clk with data 1,2,3,4,5 -> out_data 1,2,3,4 each one cycle after its ad_vld. Then done pulses once, busy falls, state=0, sample 5 is not output.
2. Mode 1, trig_level=100, data 50,90,120,130,80: -> first output is 120 and num_samp=3 gives 120,130,80. Repeat with mode 2, trig_level=100, data 120,130,80,70,60 -> outputs 80,70,60.
3. Mode 0, decim=2, num_samp=3, data 0..9 -> outputs 0,3,6, then done; samp_cnt=3.
4. out_rdy=0, mode 0, num_samp=5, decim=0 -> buffer holds 1,2, samples 3..5 dropped, ovf=1, samp_cnt=5, state=FLUSH. Then out_rdy=1 -> 1,2 drained, done pulses; next start clears ovf.
5. Mode 3, trig_ext rises between two ad_vld -> first kept sample is the ad_vld after the edge. Mode 3 with trig_ext held high from before start -> no trigger.
6. abort mid-CAPTURE with 1 sample buffered -> out_vld=0 next cycle, state=0, no done. start pulsed while busy -> ignored. rst asserted mid-capture -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ad_acq_ctrl.sv
// Acquisition controller between the ADC deserialiser and a downstream sample consumer.
// Arms on start, waits for a selectable trigger, captures num_samp decimated samples into
// a 2-entry output buffer (valid/ready), then drains and pulses done.
//
// Ports:
//   clk_sys, rst          - clock (rising edge), asynchronous active-high reset
//   start, abort          - one-cycle control pulses (abort has priority)
//   trig_mode/level/ext   - trigger select, signed threshold, external trigger level
//   decim, num_samp       - keep 1 of decim+1 samples; capture length (0 = continuous)
//   ad_data, ad_vld       - sample stream from the deserialiser
//   out_data/vld/rdy      - buffered sample handshake toward the consumer
//   busy, done, ovf       - status: not idle, capture drained, sticky sample drop
//   state, samp_cnt       - FSM state and kept-sample count for readback
module ad_acq_ctrl #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    trig_mode,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_ext,
  input  logic [7:0]    decim,
  input  logic [CW-1:0] num_samp,
  input  logic [DW-1:0] ad_data,
  input  logic          ad_vld,
  output logic [DW-1:0] out_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic [1:0]    state,
  output logic [CW-1:0] samp_cnt
);

  typedef enum logic [1:0] {StIdle = 2'd0, StWaitTrig = 2'd1, StCapture = 2'd2, StFlush = 2'd3}
    state_e;

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [DW-1:0] level_q, level_d;
  logic [7:0]    decim_q, decim_d;
  logic [CW-1:0] nsamp_q, nsamp_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          ext_q;
  logic          ext_pend_q, ext_pend_d;
  logic [7:0]    dc_q, dc_d;
  logic [CW-1:0] samp_cnt_q, samp_cnt_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic [DW-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]    cnt_q, cnt_d;

  logic          accept, ext_edge, is_trig, trig_hit, keep_cap, push, pop;
  logic [CW-1:0] cnt_inc;

  assign accept   = start && !abort && (state_q == StIdle);
  assign ext_edge = trig_ext && !ext_q;
  assign pop      = (cnt_q != 2'd0) && out_rdy;
  assign cnt_inc  = samp_cnt_q + CW'(1);

  always_comb begin
    is_trig = 1'b0;
    unique case (mode_q)
      2'd0: is_trig = 1'b1;
      2'd1: is_trig = ($signed(prev_q) < $signed(level_q)) &&
                      ($signed(level_q) <= $signed(ad_data));
      2'd2: is_trig = ($signed(prev_q) > $signed(level_q)) &&
                      ($signed(level_q) >= $signed(ad_data));
      // An edge seen on the same cycle as ad_vld counts too.
      default: is_trig = ext_pend_q || ext_edge;
    endcase
  end

  assign trig_hit = (state_q == StWaitTrig) && ad_vld && is_trig && !abort;
  assign keep_cap = (state_q == StCapture) && ad_vld && (dc_q == decim_q) && !abort;
  assign push     = trig_hit || keep_cap;

  // FSM and counters
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    level_d    = level_q;
    decim_d    = decim_q;
    nsamp_d    = nsamp_q;
    prev_d     = prev_q;
    ext_pend_d = ext_pend_q;
    dc_d       = dc_q;
    samp_cnt_d = samp_cnt_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        ext_pend_d = 1'b0;
        if (accept) begin
          state_d    = StWaitTrig;
          mode_d     = trig_mode;
          level_d    = trig_level;
          decim_d    = decim;
          nsamp_d    = num_samp;
          prev_d     = ad_data;
          dc_d       = 8'd0;
          samp_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end
      StWaitTrig: begin
        if (ad_vld) prev_d = ad_data;
        if (ext_edge) ext_pend_d = 1'b1;
        if (trig_hit) begin
          samp_cnt_d = CW'(1);
          dc_d       = 8'd0;
          state_d    = (nsamp_q == CW'(1)) ? StFlush : StCapture;
        end
      end
      StCapture: begin
        ext_pend_d = 1'b0;
        if (ad_vld) dc_d = (dc_q == decim_q) ? 8'd0 : dc_q + 8'd1;
        if (keep_cap) begin
          samp_cnt_d = cnt_inc;
          if ((nsamp_q != '0) && (cnt_inc == nsamp_q)) state_d = StFlush;
        end
      end
      default: begin
        ext_pend_d = 1'b0;
        if (cnt_q == 2'd0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
    endcase

    // Full buffer with no pop: drop the kept sample but still count it.
    if (push && (cnt_q == 2'd2) && !pop) ovf_d = 1'b1;

    if (abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
  end

  // 2-entry buffer; buf0 is the head and drives out_data directly.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    unique case (cnt_q)
      2'd0: begin
        if (push) begin
          buf0_d = ad_data;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          buf0_d = ad_data;
        end else if (push) begin
          buf1_d = ad_data;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          buf0_d = buf1_q;
          if (push) buf1_d = ad_data;
          else      cnt_d  = 2'd1;
        end
      end
    endcase
    if (abort) cnt_d = 2'd0;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= 2'd0;
      level_q    <= '0;
      decim_q    <= 8'd0;
      nsamp_q    <= '0;
      prev_q     <= '0;
      ext_q      <= 1'b0;
      ext_pend_q <= 1'b0;
      dc_q       <= 8'd0;
      samp_cnt_q <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      level_q    <= level_d;
      decim_q    <= decim_d;
      nsamp_q    <= nsamp_d;
      prev_q     <= prev_d;
      ext_q      <= trig_ext;
      ext_pend_q <= ext_pend_d;
      dc_q       <= dc_d;
      samp_cnt_q <= samp_cnt_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_data = buf0_q;
  assign out_vld  = (cnt_q != 2'd0);
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign state    = state_q;
  assign samp_cnt = samp_cnt_q;

endmodule
